// File: rtl/id_pool_allocator.sv
// id_pool_allocator: hands out the lowest-numbered free transaction ID and
// reclaims IDs on completion. The pool state is a free mask (1 = free) plus a
// count of allocated IDs; flush returns every ID to the pool.
//
// Optional feature: define ID_POOL_ALLOCATOR_ERR_CHECK_EN to make a bad free
// (an ID that is already free, or an ID >= NUM_IDS) raise a sticky err_o that
// only rst_i clears. Without the macro such frees are silently ignored and
// err_o is tied low.

package cf_math_pkg;
  // Width of an index into num_idx entries; never less than one bit.
  function automatic integer idx_width(input integer num_idx);
    return (num_idx > 1) ? $clog2(num_idx) : 1;
  endfunction
endpackage

module id_pool_allocator #(
  parameter int unsigned NUM_IDS = 8,
  parameter int unsigned IDX_W   = cf_math_pkg::idx_width(NUM_IDS),
  parameter int unsigned CNT_W   = $clog2(NUM_IDS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  output logic             alloc_valid_o,
  input  logic             alloc_ready_i,
  output logic [IDX_W-1:0] alloc_id_o,
  input  logic             free_valid_i,
  output logic             free_ready_o,
  input  logic [IDX_W-1:0] free_id_i,
  output logic [CNT_W-1:0] used_cnt_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             err_o
);

  localparam logic [IDX_W:0]   NUM_IDS_IDX = (IDX_W + 1)'(NUM_IDS);
  localparam logic [CNT_W-1:0] NUM_IDS_CNT = CNT_W'(NUM_IDS);

  logic [NUM_IDS-1:0] free_q, free_d;
  logic [CNT_W-1:0]   used_q, used_d;
  logic [IDX_W-1:0]   lowest_free;
  logic               any_free;
  logic               alloc_fire;
  logic               free_fire;
  logic               free_in_range;
  logic               free_busy;
  logic               free_ok;

  // Trailing-zero count of the free mask: scan from the top so the lowest
  // set bit is the last one written. An empty mask yields ID 0.
  always_comb begin
    lowest_free = '0;
    for (int i = int'(NUM_IDS) - 1; i >= 0; i--) begin
      if (free_q[i]) lowest_free = IDX_W'(i);
    end
  end

  assign any_free = |free_q;

  // Offer side never looks at alloc_ready_i, so a consumer may make its ready
  // depend on alloc_valid_o without forming a combinational loop.
  assign alloc_valid_o = !rst_i && any_free && !flush_i;
  assign alloc_id_o    = rst_i ? '0 : lowest_free;
  assign alloc_fire    = alloc_valid_o && alloc_ready_i;

  assign free_ready_o  = !rst_i;
  assign free_fire     = free_valid_i && free_ready_o;
  assign free_in_range = {1'b0, free_id_i} < NUM_IDS_IDX;
  // The range test guards the mask lookup so a non-power-of-two pool never
  // indexes past its last slot.
  assign free_busy     = free_in_range && !free_q[free_id_i];
  assign free_ok       = free_fire && free_busy;

  assign used_cnt_o = used_q;
  assign full_o     = !rst_i && (used_q == NUM_IDS_CNT);
  assign empty_o    = rst_i || (used_q == '0);

  // Next-state logic for the free mask and the allocation count.
  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    free_d = free_q;
    used_d = used_q;
    if (flush_i) begin
      free_d = '1;
      used_d = '0;
    end else begin
      // Alloc clears the offered bit and a valid free sets a busy bit; the two
      // can never target the same ID, and the freed ID is not bypassed onto
      // alloc_id_o until the mask register holds it.
      if (alloc_fire) free_d[lowest_free] = 1'b0;
      if (free_ok)    free_d[free_id_i]   = 1'b1;
      unique case ({alloc_fire, free_ok})
        2'b10:   used_d = used_q + CNT_W'(1);
        2'b01:   used_d = used_q - CNT_W'(1);
        default: used_d = used_q;
      endcase
    end
  end

  // Pool state register; synchronous reset returns every ID to the pool.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      free_q <= '1;
      used_q <= '0;
    end else begin
      free_q <= free_d;
      used_q <= used_d;
    end
  end

`ifdef ID_POOL_ALLOCATOR_ERR_CHECK_EN
  logic err_q;

  // Sticky protocol error: a free of an already-free or out-of-range ID.
  // Handshakes dropped by flush do not count, and only rst_i clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (!flush_i && free_fire && !free_busy) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_id_pool_allocator.sv
// Self-checking bench for id_pool_allocator. Three instances share one clock:
// an 8-entry pool for directed scenarios, a 10-entry pool for bad-free
// handling, and a 5-entry pool driven randomly against a free-set model.
module tb_id_pool_allocator;

`ifdef ID_POOL_ALLOCATOR_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- 8-entry instance ----------------
  logic       a_rst = 1'b1, a_flush = 1'b0, a_ready = 1'b0, a_fvalid = 1'b0;
  logic [2:0] a_fid = '0;
  logic       a_valid, a_fready, a_full, a_empty, a_err;
  logic [2:0] a_id;
  logic [3:0] a_used;

  id_pool_allocator #(.NUM_IDS(8)) dut8 (
    .clk_i(clk), .rst_i(a_rst), .flush_i(a_flush),
    .alloc_valid_o(a_valid), .alloc_ready_i(a_ready), .alloc_id_o(a_id),
    .free_valid_i(a_fvalid), .free_ready_o(a_fready), .free_id_i(a_fid),
    .used_cnt_o(a_used), .full_o(a_full), .empty_o(a_empty), .err_o(a_err)
  );

  // ---------------- 10-entry instance ----------------
  logic       c_rst = 1'b1, c_flush = 1'b0, c_ready = 1'b0, c_fvalid = 1'b0;
  logic [3:0] c_fid = '0;
  logic       c_valid, c_fready, c_full, c_empty, c_err;
  logic [3:0] c_id;
  logic [3:0] c_used;

  id_pool_allocator #(.NUM_IDS(10)) dut10 (
    .clk_i(clk), .rst_i(c_rst), .flush_i(c_flush),
    .alloc_valid_o(c_valid), .alloc_ready_i(c_ready), .alloc_id_o(c_id),
    .free_valid_i(c_fvalid), .free_ready_o(c_fready), .free_id_i(c_fid),
    .used_cnt_o(c_used), .full_o(c_full), .empty_o(c_empty), .err_o(c_err)
  );

  // ---------------- 5-entry instance ----------------
  logic       b_rst = 1'b1, b_flush = 1'b0, b_ready = 1'b0, b_fvalid = 1'b0;
  logic [2:0] b_fid = '0;
  logic       b_valid, b_fready, b_full, b_empty, b_err;
  logic [2:0] b_id;
  logic [2:0] b_used;

  id_pool_allocator #(.NUM_IDS(5)) dut5 (
    .clk_i(clk), .rst_i(b_rst), .flush_i(b_flush),
    .alloc_valid_o(b_valid), .alloc_ready_i(b_ready), .alloc_id_o(b_id),
    .free_valid_i(b_fvalid), .free_ready_o(b_fready), .free_id_i(b_fid),
    .used_cnt_o(b_used), .full_o(b_full), .empty_o(b_empty), .err_o(b_err)
  );

  // Reference model for the 5-entry pool: the set of free IDs and the sticky error.
  bit free_m[5];
  bit err_m;

  initial begin
    // ---- reset: outputs forced while rst is high ----
    #1;
    check("rst_valid", a_valid, 0);
    check("rst_fready", a_fready, 0);
    check("rst_id", a_id, 0);
    check("rst_empty", a_empty, 1);
    check("rst_full", a_full, 0);
    step();
    check("rst_used", a_used, 0);
    a_rst = 1'b0; c_rst = 1'b0; b_rst = 1'b0;
    #1;
    check("init_used", a_used, 0);
    check("init_empty", a_empty, 1);
    check("init_valid", a_valid, 1);
    check("init_fready", a_fready, 1);
    check("init_err", a_err, 0);

    // ---- fill the 8-entry pool in order ----
    a_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("fill_id%0d", i), a_id, i);
      check($sformatf("fill_valid%0d", i), a_valid, 1);
      step();
    end
    a_ready = 1'b0;
    #1;
    check("full_full", a_full, 1);
    check("full_valid", a_valid, 0);
    check("full_used", a_used, 8);
    check("full_id", a_id, 0);
    check("full_empty", a_empty, 0);

    // ---- free 5 then 2: lowest free wins ----
    a_fvalid = 1'b1; a_fid = 3'd5;
    step();
    a_fid = 3'd2;
    #1;
    check("free5_id", a_id, 5);
    check("free5_used", a_used, 7);
    check("free5_full", a_full, 0);
    step();
    a_fvalid = 1'b0;
    #1;
    check("free2_id", a_id, 2);
    check("free2_used", a_used, 6);

    // ---- flush, then simultaneous alloc and free ----
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    #1;
    check("flush1_used", a_used, 0);
    check("flush1_empty", a_empty, 1);
    a_ready = 1'b1;
    step(); step(); step();
    a_fvalid = 1'b1; a_fid = 3'd1;
    #1;
    check("both_id", a_id, 3);
    check("both_used_pre", a_used, 3);
    step();
    a_ready = 1'b0; a_fvalid = 1'b0;
    #1;
    check("both_used", a_used, 3);
    check("both_next_id", a_id, 1);

    // ---- reach used=6 (IDs 1,4,5), then flush with an alloc handshake ----
    a_ready = 1'b1;
    step(); step(); step();
    a_ready = 1'b0;
    #1;
    check("six_used", a_used, 6);
    check("six_id", a_id, 6);
    a_flush = 1'b1; a_ready = 1'b1;
    #1;
    check("flush_valid", a_valid, 0);
    step();
    a_flush = 1'b0; a_ready = 1'b0;
    #1;
    check("flush2_used", a_used, 0);
    check("flush2_empty", a_empty, 1);
    check("flush2_id", a_id, 0);
    check("flush2_full", a_full, 0);

    // ---- reset mid-operation ----
    a_ready = 1'b1;
    step(); step();
    a_ready = 1'b0;
    #1;
    check("mid_used_pre", a_used, 2);
    a_rst = 1'b1;
    #1;
    check("mid_rst_valid", a_valid, 0);
    check("mid_rst_id", a_id, 0);
    check("mid_rst_empty", a_empty, 1);
    check("mid_rst_fready", a_fready, 0);
    step();
    a_rst = 1'b0;
    #1;
    check("mid_used", a_used, 0);
    check("mid_id", a_id, 0);
    check("mid_valid", a_valid, 1);

    // ---- bad frees on the 10-entry pool ----
    c_fvalid = 1'b1; c_fid = 4'd4;
    #1;
    check("bad4_err_pre", c_err, 0);
    step();
    c_fid = 4'd9;
    #1;
    check("bad4_err", c_err, ERR_EN);
    check("bad4_used", c_used, 0);
    check("bad4_id", c_id, 0);
    step();
    c_fid = 4'd12;
    #1;
    check("bad9_err", c_err, ERR_EN);
    check("bad9_used", c_used, 0);
    step();
    c_fvalid = 1'b0;
    #1;
    check("bad12_used", c_used, 0);
    check("bad12_id", c_id, 0);
    check("bad12_empty", c_empty, 1);
    c_ready = 1'b1;
    step();
    c_ready = 1'b0; c_fvalid = 1'b1; c_fid = 4'd0;
    #1;
    check("c_alloc_used", c_used, 1);
    check("c_alloc_id", c_id, 1);
    step();
    c_fvalid = 1'b0;
    #1;
    check("c_free_used", c_used, 0);
    check("c_free_id", c_id, 0);
    check("c_free_err", c_err, ERR_EN);
    c_flush = 1'b1;
    step();
    c_flush = 1'b0;
    #1;
    check("c_flush_err", c_err, ERR_EN);
    c_rst = 1'b1;
    step();
    c_rst = 1'b0;
    #1;
    check("c_rst_err", c_err, 0);

    // ---- random traffic on the 5-entry pool ----
    foreach (free_m[i]) free_m[i] = 1'b1;
    err_m = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int  lo;
      int  nfree;
      bit  ok;
      b_flush  = ($urandom_range(63) == 0);
      b_ready  = 1'($urandom_range(1));
      b_fvalid = 1'($urandom_range(1));
      b_fid    = 3'($urandom_range(7));
      #1;
      lo = 0;
      nfree = 0;
      for (int i = 4; i >= 0; i--) begin
        if (free_m[i]) begin
          lo = i;
          nfree++;
        end
      end
      check("rnd_id", b_id, lo);
      check("rnd_valid", b_valid, (nfree > 0) && !b_flush);
      check("rnd_used", b_used, 5 - nfree);
      check("rnd_full", b_full, nfree == 0);
      check("rnd_empty", b_empty, nfree == 5);
      check("rnd_err", b_err, err_m);
      if (b_flush) begin
        foreach (free_m[i]) free_m[i] = 1'b1;
      end else begin
        ok = (b_fid < 5) && !free_m[b_fid];
        if (nfree > 0 && b_ready) free_m[lo] = 1'b0;
        if (b_fvalid) begin
          if (ok) free_m[b_fid] = 1'b1;
          else if (ERR_EN) err_m = 1'b1;
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
